// File: rtl/mos_bus_resolver.sv
// Switch-level bus resolver: NMOS/PMOS pass channels onto a shared bus,
// with per-bit strength resolution, a decaying keeper and contention stats.
module mos_bus_resolver #(
    parameter int             WIDTH       = 8,
    parameter int             NCH         = 4,
    parameter logic [NCH-1:0] NMOS_MASK   = {NCH{1'b1}},
    parameter int             KEEP_CYCLES = 4,
    parameter int             CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] a,
    input  logic [NCH-1:0]       c,
    input  logic                 clr_cnt,
    output logic [WIDTH-1:0]     bus_val,
    output logic [WIDTH-1:0]     bus_drv,
    output logic [WIDTH-1:0]     bus_weak,
    output logic [WIDTH-1:0]     bus_x,
    output logic [CNT_W-1:0]     cont_cnt,
    output logic                 cont_flag
);

    localparam int KW = (KEEP_CYCLES > 0) ? $clog2(KEEP_CYCLES + 1) : 1;
    localparam logic [KW-1:0] KLOAD =
        KW'((KEEP_CYCLES > 0) ? KEEP_CYCLES - 1 : 0);

    localparam logic [1:0] S_FLOAT = 2'd0;
    localparam logic [1:0] S_DRV   = 2'd1;
    localparam logic [1:0] S_KEPT  = 2'd2;
    localparam logic [1:0] S_CONT  = 2'd3;

    logic [WIDTH-1:0] cont_now;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        logic          s0, s1, w0, w1;
        logic          drv_now, val_now, weak_now;
        logic [1:0]    st;
        logic [KW-1:0] kcnt;
        logic          kval;
        logic          wk;

        always_comb begin
            s0 = 1'b0;
            s1 = 1'b0;
            w0 = 1'b0;
            w1 = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                if (NMOS_MASK[i]) begin
                    if (c[i]) begin
                        if (a[i*WIDTH+b]) w1 = 1'b1;
                        else              s0 = 1'b1;
                    end
                end else if (!c[i]) begin
                    if (a[i*WIDTH+b]) s1 = 1'b1;
                    else              w0 = 1'b1;
                end
            end
        end

        // Any strong drive masks all weak drivers on this bit.
        always_comb begin
            cont_now[b] = 1'b0;
            drv_now     = 1'b0;
            val_now     = 1'b0;
            weak_now    = 1'b0;
            if (s0 || s1) begin
                cont_now[b] = s0 && s1;
                drv_now     = !(s0 && s1);
                val_now     = s1;
            end else if (w0 || w1) begin
                cont_now[b] = w0 && w1;
                drv_now     = !(w0 && w1);
                val_now     = w1;
                weak_now    = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                st   <= S_FLOAT;
                kcnt <= '0;
                kval <= 1'b0;
                wk   <= 1'b0;
            end else if (cont_now[b]) begin
                st <= S_CONT;
            end else if (drv_now) begin
                st   <= S_DRV;
                kval <= val_now;
                wk   <= weak_now;
            end else if (KEEP_CYCLES > 0 &&
                         (st == S_DRV ||
                          (st == S_KEPT && kcnt != '0))) begin
                st   <= S_KEPT;
                kcnt <= (st == S_DRV) ? KLOAD : kcnt - KW'(1);
            end else begin
                st <= S_FLOAT;
            end
        end

        assign bus_drv[b]  = (st == S_DRV) || (st == S_KEPT);
        assign bus_val[b]  = bus_drv[b] && kval;
        assign bus_weak[b] = (st == S_KEPT) || (st == S_DRV && wk);
        assign bus_x[b]    = (st == S_CONT);
    end

    logic any_cont;
    assign any_cont = |cont_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            cont_cnt  <= '0;
            cont_flag <= 1'b0;
        end else if (clr_cnt) begin
            cont_cnt  <= CNT_W'(any_cont);
            cont_flag <= any_cont;
        end else if (any_cont) begin
            if (cont_cnt != {CNT_W{1'b1}})
                cont_cnt <= cont_cnt + CNT_W'(1);
            cont_flag <= 1'b1;
        end
    end

endmodule

// File: doc/mos_bus_resolver.md
# mos_bus_resolver

Parametrised switch-level bus resolver: NCH NMOS/PMOS pass-transistor channels drive a shared WIDTH-bit bus, and the block resolves per-bit strength (strong, weak, kept, float, contention) into a registered bus state. It generalises the single NMOS/PMOS strength pair to multiple channels, adds a decaying bus keeper and contention statistics. It sits between channel drivers and any consumer that needs a cycle-accurate resolved bus view.

## Interface
- WIDTH, 8, bus width in bits (≥1)
- NCH, 4, number of driver channels (≥1)
- NMOS_MASK, {NCH{1'b1}}, bit i=1: channel i is NMOS; 0: PMOS
- KEEP_CYCLES, 4, cycles a released bit holds its last value (0 = no keeper)
- CNT_W, 8, contention counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- a  in  NCH*WIDTH  channel data; channel i occupies a[i*WIDTH +: WIDTH]
- c  in  NCH  channel gate
- clr_cnt  in  1  clears contention counter and sticky flag
- bus_val  out  WIDTH  resolved value per bit
- bus_drv  out  WIDTH  1 = bit driven or kept; 0 = float
- bus_weak  out  WIDTH  1 = winning drive is weak or keeper
- bus_x  out  WIDTH  1 = contention on bit
- cont_cnt  out  CNT_W  cycles with any bus_x bit set, saturating
- cont_flag  out  1  sticky: contention seen since reset/clear

## Operation
- Per channel, per bit: NMOS conducts when c[i]=1, PMOS when c[i]=0; otherwise Z.
- NMOS passing 0 → strong 0; passing 1 → weak 1. PMOS passing 1 → strong 1; passing 0 → weak 0.
- Per-bit resolution, highest first: strong beats weak beats keeper beats Z. Strong 0 and strong 1 both present → contention. No strong and weak 0 and weak 1 both present → contention.
- Per-bit state FLOAT / DRIVEN / KEPT / CONT, with a keeper counter of width clog2(KEEP_CYCLES+1):
  - any contention → CONT (bus_x=1, bus_drv=0, bus_val=0, bus_weak=0)
  - non-conflicting drive → DRIVEN (bus_val=winner, bus_drv=1, bus_weak per winner); keeper value updated
  - no drive, from DRIVEN or KEPT, KEEP_CYCLES>0 → KEPT (bus_val=keeper value, bus_drv=1, bus_weak=1)
  - KEPT persists exactly KEEP_CYCLES output cycles after the first released sample, then FLOAT
  - no drive, from CONT or FLOAT, or KEEP_CYCLES=0 → FLOAT (bus_drv=0, bus_val=0, bus_weak=0); a contended value is never kept
  - drive during KEPT → DRIVEN; keeper counter reloads on every later release
- cont_cnt increments by 1 each cycle in which any bit resolves to CONT, saturating at 2^CNT_W−1. cont_flag is set on the same cycle and stays set.
- clr_cnt=1: cont_cnt ← (contention this cycle ? 1 : 0); cont_flag ← contention this cycle.

## Timing
- Latency: inputs sampled at edge t appear on all outputs after edge t (one register stage). There is no combinational input→output path.
- Reset, taking precedence over clr_cnt: every bit FLOAT, keeper values 0, bus_val=0, bus_drv=0, bus_weak=0, bus_x=0, cont_cnt=0, cont_flag=0.
- Reset asserted mid-KEPT or mid-CONT: the next cycle shows the reset values; keeper history is lost.
- Bits are fully independent; mixed states across bits in one cycle are legal.

## Test plan
- Defaults with NMOS_MASK=4'b0011: ch0 c=1, a=8'h00, others off → next cycle bus_val=00, bus_drv=FF, bus_weak=00, bus_x=00.
- Same, but ch0 a=8'hFF → bus_val=FF, bus_weak=FF. Then ch2 (PMOS) c=0, a=8'hFF, ch0 off → bus_weak=00.
- Drive 8'hA5 strong (ch0 a=A5 and ch2 a=A5), then release all → bus_val=A5 with bus_weak=FF for exactly 4 cycles, then bus_drv=00, bus_val=00. Redrive during the keep window → DRIVEN next cycle and the window restarts on release.
- Contention: ch0 a=00 (c=1), ch2 a=0F (c=0) → bus_x=0F, bus_drv=F0, cont_cnt increments each cycle, cont_flag=1. Release → bits 3:0 FLOAT immediately with no keeper.
- CNT_W=2 with 5 contention cycles → cont_cnt saturates at 3. clr_cnt during contention → cont_cnt=1; clr_cnt without contention → 0 and cont_flag=0.
- rst asserted during KEPT with nonzero cont_cnt → next cycle all outputs 0; KEEP_CYCLES=0 build: release → FLOAT the next cycle.
